// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: instruction memory controller.
// IDLE/HALT let a loader write words into the external memory. FETCH walks
// the PC, issues 1-cycle synchronous word reads and hands instructions to
// decode through a 2-entry valid/ready queue. Redirects flush and restart
// fetch; a misaligned or out-of-range PC halts with a sticky fault once the
// queue has drained.
// Optional build macro IMEM_HALT_ON_ZERO_EN: a returned all-zero word stops
// fetch and halts cleanly (fault=0) once earlier instructions have drained.
module imem_fetch_ctrl #(
   parameter int          DEPTH    = 32,
   parameter int          ADDR_W   = 5,
   parameter logic [31:0] START_PC = 32'h0000_0000
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              load_valid,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [31:0]       load_data,
   output logic              load_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic              redirect_valid,
   input  logic [31:0]       redirect_pc,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [31:0]       inst,
   output logic [31:0]       inst_pc,
   output logic [31:0]       pc,
   output logic              halted,
   output logic              fault
);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HALT} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        pend_q, pend_d;     // a read was issued last cycle
   logic [31:0] tag_q, tag_d;       // byte PC of the pending read
   logic [1:0]  count_q, count_d;   // queue occupancy 0..2
   logic        head_q, head_d;
   logic        fault_q, fault_d;
   logic [31:0] qdata_q [2];
   logic [31:0] qpc_q   [2];

   logic        in_fetch, redir, pc_legal, pop, push_raw, push, issue, load_wr;
   logic        room, zero_block, wr_idx;
   logic [1:0]  occ_eff;

   assign in_fetch = (state_q == S_FETCH);
   assign redir    = in_fetch && redirect_valid;
   assign pc_legal = (pc_q[1:0] == 2'b00) && (pc_q[31:2] < 30'(DEPTH));

   assign inst_valid = (state_q != S_HALT) && (count_q != 2'd0);
   assign inst       = qdata_q[head_q];
   assign inst_pc    = qpc_q[head_q];
   assign pop        = inst_valid && inst_ready;

   // Data returning from the read issued last cycle, unless a redirect kills it.
   assign push_raw = in_fetch && pend_q && !redir;

`ifdef IMEM_HALT_ON_ZERO_EN
   logic zero_q, zero_d, zero_hit;
   assign zero_hit   = push_raw && (mem_rdata == 32'h0000_0000);
   assign push       = push_raw && !zero_hit;
   assign zero_block = zero_q || zero_hit;
`else
   assign push       = push_raw;
   assign zero_block = 1'b0;
`endif

   // Occupancy after this cycle's pop lets a stream run at 1/cycle while the
   // in-flight read plus stored entries never exceed the two queue slots.
   assign occ_eff = count_q - {1'b0, pop};
   assign room    = (occ_eff + {1'b0, pend_q}) < 2'd2;
   assign issue   = in_fetch && !redir && pc_legal && room && !zero_block;
   assign wr_idx  = head_q ^ count_q[0];

   assign load_ready = !in_fetch && !reset;
   assign load_wr    = load_ready && load_valid;
   assign halted     = (state_q == S_HALT);
   assign fault      = fault_q;
   assign pc         = pc_q;

   // Memory port: loader writes win; otherwise drive the fetch read address.
   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = 32'h0;
      if (load_wr) begin
         mem_we    = 1'b1;
         mem_addr  = load_addr;
         mem_wdata = load_data;
      end else if (issue) begin
         mem_addr = pc_q[ADDR_W+1:2];
      end
   end

   // Next-state logic for the FSM, PC sequencing and queue bookkeeping.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      pend_d  = pend_q;
      tag_d   = tag_q;
      fault_d = fault_q;
      count_d = count_q + {1'b0, push} - {1'b0, pop};
      head_d  = head_q ^ pop;
`ifdef IMEM_HALT_ON_ZERO_EN
      zero_d  = zero_q;
`endif
      case (state_q)
         S_IDLE, S_HALT: begin
            if (start && !load_valid) begin
               state_d = S_FETCH;
               pc_d    = START_PC;
               pend_d  = 1'b0;
               fault_d = 1'b0;
               count_d = 2'd0;
`ifdef IMEM_HALT_ON_ZERO_EN
               zero_d  = 1'b0;
`endif
            end
         end
         S_FETCH: begin
            if (redir) begin
               pc_d    = redirect_pc;
               pend_d  = 1'b0;
               count_d = 2'd0;
`ifdef IMEM_HALT_ON_ZERO_EN
               zero_d  = 1'b0;
`endif
            end else begin
               pend_d = issue;
               if (issue) begin
                  tag_d = pc_q;
                  pc_d  = pc_q + 32'd4;
               end
`ifdef IMEM_HALT_ON_ZERO_EN
               if (zero_hit)
                  zero_d = 1'b1;
               if (zero_q && count_q == 2'd0) begin
                  state_d = S_HALT;
               end else
`endif
               if (!pc_legal && count_q == 2'd0 && !pend_q) begin
                  state_d = S_HALT;
                  fault_d = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Control state registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
         pc_q    <= START_PC;
         pend_q  <= 1'b0;
         tag_q   <= 32'h0;
         count_q <= 2'd0;
         head_q  <= 1'b0;
         fault_q <= 1'b0;
`ifdef IMEM_HALT_ON_ZERO_EN
         zero_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         pend_q  <= pend_d;
         tag_q   <= tag_d;
         count_q <= count_d;
         head_q  <= head_d;
         fault_q <= fault_d;
`ifdef IMEM_HALT_ON_ZERO_EN
         zero_q  <= zero_d;
`endif
      end
   end

   // Queue slots: capture returning word and its PC at the tail.
   for (genvar gi = 0; gi < 2; gi++) begin : g_slot
      always_ff @(posedge clock) begin
         if (reset) begin
            qdata_q[gi] <= 32'h0;
            qpc_q[gi]   <= 32'h0;
         end else if (push && (wr_idx == 1'(gi))) begin
            qdata_q[gi] <= mem_rdata;
            qpc_q[gi]   <= tag_q;
         end
      end
   end

endmodule
